// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline port A always wins; late load
// returns on port B wait in an in-order queue and are squashed by newer A writes.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [3:0]  a_reg,
  input  logic [15:0] a_data,
  input  logic        b_valid,
  input  logic [3:0]  b_reg,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic        wr_en,
  output logic [3:0]  wr_reg,
  output logic [15:0] wr_data,
  input  logic [3:0]  chk_reg1,
  input  logic [3:0]  chk_reg2,
  output logic        chk_hit1,
  output logic        chk_hit2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [3:0]       reg_mem_q  [DEPTH];
  logic [15:0]      data_mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_reg_q, wr_reg_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic sel_a, push, pop, push_vld;

  assign sel_a    = a_valid && (a_reg != 4'd0);
  assign b_ready  = rst_n && (count_q < CNT_W'(DEPTH));
  // b_reg=0 transfers are accepted but never occupy a slot
  assign push     = b_valid && b_ready && (b_reg != 4'd0);
  assign pop      = !sel_a && (count_q != '0);
  assign push_vld = !(sel_a && (a_reg == b_reg));

  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // an accepted A write makes every older queued write to that register stale
    if (sel_a) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (reg_mem_q[i] == a_reg) vld_d[i] = 1'b0;
      end
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      vld_d[wr_ptr_q] = push_vld;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (sel_a) begin
      wr_en_d   = 1'b1;
      wr_reg_d  = a_reg;
      wr_data_d = a_data;
    end else if (pop) begin
      wr_en_d   = vld_q[rd_ptr_q];
      wr_reg_d  = reg_mem_q[rd_ptr_q];
      wr_data_d = data_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= 4'd0;
      wr_data_q <= 16'd0;
    end else begin
      vld_q     <= vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Payload storage needs no reset: slots are only observed through vld_q.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem_q[wr_ptr_q]  <= b_reg;
      data_mem_q[wr_ptr_q] <= b_data;
    end
  end

  always_comb begin
    chk_hit1 = 1'b0;
    chk_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (chk_reg1 != 4'd0) && (reg_mem_q[i] == chk_reg1)) chk_hit1 = 1'b1;
      if (vld_q[i] && (chk_reg2 != 4'd0) && (reg_mem_q[i] == chk_reg2)) chk_hit2 = 1'b1;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: port-B writes are queued in a
// scoreboard when driven and popped when the write port emits them.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [3:0]  a_reg;
  logic [15:0] a_data;
  logic        b_valid;
  logic [3:0]  b_reg;
  logic [15:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic [3:0]  chk_reg1;
  logic [3:0]  chk_reg2;
  logic        chk_hit1;
  logic        chk_hit2;

  typedef struct packed {
    logic [3:0]  r;
    logic [15:0] d;
  } wr_t;

  wr_t sb_q[$];
  wr_t exp_w;
  int  n_chk = 0;
  int  n_err = 0;

  regfile_wb_arbiter #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_reg    (a_reg),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_reg    (b_reg),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .wr_en    (wr_en),
    .wr_reg   (wr_reg),
    .wr_data  (wr_data),
    .chk_reg1 (chk_reg1),
    .chk_reg2 (chk_reg2),
    .chk_hit1 (chk_hit1),
    .chk_hit2 (chk_hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] r, input logic [15:0] d);
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(en));
    chk({tag, ".wr_reg"}, 32'(wr_reg), 32'(r));
    chk({tag, ".wr_data"}, 32'(wr_data), 32'(d));
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0; chk_reg1 = '0; chk_reg2 = '0;

    // reset state
    tick(); tick();
    chk_wr("reset", 1'b0, 4'd0, 16'd0);
    chk("reset.b_ready", 32'(b_ready), 32'd0);
    chk("reset.count", 32'(dut.count_q), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release.b_ready", 32'(b_ready), 32'd1);

    // port A alone
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1234;
    tick();
    a_valid = 1'b0;
    chk_wr("portA", 1'b1, 4'd3, 16'h1234);

    // port B alone: visible to chk one cycle later, written two cycles later
    b_valid = 1'b1; b_reg = 4'd5; b_data = 16'hBEEF; chk_reg1 = 4'd5;
    sb_q.push_back(wr_t'{4'd5, 16'hBEEF});
    tick();
    b_valid = 1'b0;
    chk("portB.hit", 32'(chk_hit1), 32'd1);
    chk("portB.lat1.wr_en", 32'(wr_en), 32'd0);
    tick();
    exp_w = sb_q.pop_front();
    chk_wr("portB.lat2", 1'b1, exp_w.r, exp_w.d);
    chk("portB.hit_after", 32'(chk_hit1), 32'd0);
    tick();
    chk_wr("idle_hold", 1'b0, 4'd5, 16'hBEEF);

    // fill the queue while port A occupies every cycle
    a_valid = 1'b1; a_reg = 4'd7; b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_reg = 4'(k + 1); b_data = 16'hA000 + 16'(k); a_data = 16'h0700 + 16'(k);
      sb_q.push_back(wr_t'{4'(k + 1), 16'hA000 + 16'(k)});
      tick();
      chk_wr("fill.portA", 1'b1, 4'd7, 16'h0700 + 16'(k));
    end
    b_valid = 1'b0;
    chk("fill.b_ready_full", 32'(b_ready), 32'd0);
    chk("fill.count", 32'(dut.count_q), 32'd4);
    tick();
    chk("fill.still_full", 32'(b_ready), 32'd0);
    a_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (sb_q.size() == 0) begin
        chk("drain.sb_empty", 32'd1, 32'd0);
      end else begin
        exp_w = sb_q.pop_front();
        chk_wr("drain", 1'b1, exp_w.r, exp_w.d);
      end
      if (k == 0) chk("drain.b_ready", 32'(b_ready), 32'd1);
    end
    chk("drain.count", 32'(dut.count_q), 32'd0);
    tick();
    chk("drain.idle_wr_en", 32'(wr_en), 32'd0);

    // squash: queued reg 9 overtaken by port A write to reg 9
    chk_reg1 = 4'd9;
    b_valid = 1'b1; b_reg = 4'd9; b_data = 16'h0001;
    tick();
    b_valid = 1'b0;
    chk("squash.hit_before", 32'(chk_hit1), 32'd1);
    a_valid = 1'b1; a_reg = 4'd9; a_data = 16'h0002;
    tick();
    a_valid = 1'b0;
    chk_wr("squash.portA", 1'b1, 4'd9, 16'h0002);
    chk("squash.hit_after", 32'(chk_hit1), 32'd0);
    tick();
    chk("squash.pop_wr_en", 32'(wr_en), 32'd0);
    chk("squash.count", 32'(dut.count_q), 32'd0);

    // same-cycle A and B to the same register: B pushed invalid
    a_valid = 1'b1; a_reg = 4'd9; a_data = 16'h0003;
    b_valid = 1'b1; b_reg = 4'd9; b_data = 16'h0004;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk_wr("sameA_B.portA", 1'b1, 4'd9, 16'h0003);
    chk("sameA_B.hit", 32'(chk_hit1), 32'd0);
    chk("sameA_B.count", 32'(dut.count_q), 32'd1);
    tick();
    chk("sameA_B.pop_wr_en", 32'(wr_en), 32'd0);

    // register 0 is discarded on both ports
    a_valid = 1'b1; a_reg = 4'd0; a_data = 16'hFFFF;
    b_valid = 1'b1; b_reg = 4'd0; b_data = 16'h5555;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("reg0.wr_en", 32'(wr_en), 32'd0);
    chk("reg0.count", 32'(dut.count_q), 32'd0);
    tick();
    chk("reg0.wr_en_next", 32'(wr_en), 32'd0);

    // reset mid-operation with three entries queued
    chk_reg2 = 4'd2;
    a_valid = 1'b1; a_reg = 4'd8; a_data = 16'h0808; b_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_reg = 4'(k + 1); b_data = 16'hC000 + 16'(k);
      tick();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("rst_mid.count", 32'(dut.count_q), 32'd3);
    chk("rst_mid.hit", 32'(chk_hit2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.b_ready_low", 32'(b_ready), 32'd0);
    tick();
    chk_wr("rst_mid", 1'b0, 4'd0, 16'd0);
    chk("rst_mid.count0", 32'(dut.count_q), 32'd0);
    chk("rst_mid.hit0", 32'(chk_hit2), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_mid.b_ready_rel", 32'(b_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_mid.no_stale", 32'(wr_en), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
